// File: rtl/uart_tx.sv
// UART 8N1 transmitter for the debug serial link: a small byte FIFO with a
// valid/ready front end feeding a start/data/stop serializer.
module uart_tx #(
    parameter int CLK_FREQUENCY = 48000000,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);
    localparam int DIV   = (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [AW:0]      wptr, rptr, wptr_nxt, rptr_nxt;
    logic [7:0]       mem [FIFO_DEPTH];
    logic             empty, full_nxt, push, pop, tx_nxt, bit_end;

    // Handshake: a byte moves on every rising edge where tx_valid && tx_ready.
    // tx_ready is a register equal to !full, forced low while in reset.
    assign push     = tx_valid && tx_ready;
    assign empty    = (wptr == rptr);
    assign bit_end  = (baud_cnt == CNT_LAST);
    assign wptr_nxt = push ? wptr + (AW + 1)'(1) : wptr;
    assign rptr_nxt = pop  ? rptr + (AW + 1)'(1) : rptr;
    assign full_nxt = (wptr_nxt[AW] != rptr_nxt[AW]) &&
                      (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        pop          = 1'b0;
        tx_nxt       = 1'b1;
        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rptr[AW-1:0]];
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                tx_nxt = shift[0];
                if (bit_end) begin
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (bit_end && !empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rptr[AW-1:0]];
                    state_nxt = START;
                end else if (bit_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            tx       <= tx_nxt;
            busy     <= (state != IDLE) || !empty;
            tx_ready <= !full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= tx_data;
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default-rate instance checked by a line-decoding monitor
// against an expected-byte queue, plus a DIV=3 instance for divisor rounding.
module tb_uart_tx;
    localparam int DIV   = 417;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst_n, tx_valid, tx_ready, tx, busy;
    logic [7:0] tx_data;
    logic       rst_s_n, tx_valid_s, tx_ready_s, tx_s, busy_s;
    logic [7:0] tx_data_s;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         frames_done = 0;
    logic       mon_abort = 1'b0;
    logic       small_done = 1'b0;
    logic [7:0] exp_q[$];
    int         fall_q[$];

    uart_tx dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy)
    );

    uart_tx #(.CLK_FREQUENCY(1000000), .BAUD_RATE(300000), .FIFO_DEPTH(4)) dut_s (
        .clk(clk), .rst_n(rst_s_n), .tx_data(tx_data_s), .tx_valid(tx_valid_s),
        .tx_ready(tx_ready_s), .tx(tx_s), .busy(busy_s)
    );

    // Clock / reset-free cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drivers: called at a falling edge; returns at the falling edge after acceptance
    task automatic push_byte(input logic [7:0] d, output int acc);
        int g;
        g = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
        check("push_ready_timeout", tx_ready, 1);
        acc = cyc + 1;
        exp_q.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int g;
        g = 0;
        while (frames_done < n && g < 12 * FRAME) begin
            @(negedge clk);
            g++;
        end
        check("frames_timeout", frames_done >= n, 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 12 * FRAME) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Monitor / scoreboard: decodes every frame on tx, checking each bit lasts DIV cycles
    initial begin : monitor
        logic [9:0] bits;
        logic       width_ok, aborted;
        bits = '0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !mon_abort) begin
                fall_q.push_back(cyc);
                width_ok = 1'b1;
                aborted  = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int j = 0; j < DIV && !aborted; j++) begin
                        if (j == 0) bits[b] = tx;
                        else if (tx !== bits[b]) width_ok = 1'b0;
                        if (mon_abort) aborted = 1'b1;
                        if (!(b == 9 && j == DIV - 1)) @(negedge clk);
                    end
                end
                if (!aborted) begin
                    check("frame_shape", {bits[0], bits[9], width_ok}, 3'b011);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got byte %0d expected none", bits[8:1]);
                    end else begin
                        check("frame_byte", bits[8:1], exp_q.pop_front());
                    end
                    frames_done++;
                end
            end
        end
    end

    // Divisor rounding: DIV=3 instance sends 0x96
    initial begin : small_test
        logic [9:0]  line_s;
        logic [29:0] cap, exp_cap;
        logic        busy_last;
        int          k, g;
        line_s     = 10'b1100101100;
        rst_s_n    = 1'b0;
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
        cap        = '0;
        busy_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst_s_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_reset", tx_ready_s, 1);
        tx_valid_s = 1'b1;
        tx_data_s  = 8'h96;
        @(negedge clk);
        tx_valid_s = 1'b0;
        k = cyc;
        g = 0;
        while (tx_s !== 1'b0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("s_latency", cyc - k, 2);
        for (int i = 0; i < 30; i++) begin
            cap[i] = tx_s;
            if (i == 29) busy_last = busy_s;
            @(negedge clk);
        end
        for (int i = 0; i < 30; i++) exp_cap[i] = line_s[i / 3];
        check("s_frame_waveform", cap, exp_cap);
        check("s_busy_last_stop", busy_last, 1);
        check("s_idle_after", {tx_s, busy_s}, 2'b10);
        small_done = 1'b1;
    end

    // Stimulus
    initial begin : main
        int k, f0, base, n, g, acc;
        logic [7:0] d;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", tx_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1);

        // Single byte 0xA5
        fall_q.delete();
        push_byte(8'hA5, k);
        check("busy_at_accept", busy, 0);
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        wait_frames(1);
        f0 = fall_q[0];
        check("start_latency", f0 - k, 2);
        wait_idle();
        check("busy_fall_time", cyc - f0, FRAME);

        // Back-to-back 0x00, 0xFF, 0x55
        fall_q.delete();
        base = frames_done;
        push_byte(8'h00, acc);
        push_byte(8'hFF, acc);
        push_byte(8'h55, acc);
        wait_frames(base + 3);
        check("b2b_gap_1", fall_q[1] - fall_q[0], FRAME);
        check("b2b_gap_2", fall_q[2] - fall_q[1], FRAME);
        wait_idle();

        // FIFO full with tx_valid held high
        base = frames_done;
        n = 0;
        d = 8'h10;
        g = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (tx_ready && g < 50) begin
            exp_q.push_back(d);
            n++;
            d++;
            @(negedge clk);
            tx_data = d;
            g++;
        end
        check("full_accepts", n, 5);
        g = 0;
        while (!tx_ready && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
        check("ready_pulse_seen", tx_ready, 1);
        exp_q.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_pulse_single", tx_ready, 0);
        wait_frames(base + 6);
        wait_idle();

        // Reset during data bit 3 of 0x3C
        fall_q.delete();
        push_byte(8'h3C, acc);
        g = 0;
        while (fall_q.size() == 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("rst_frame_started", fall_q.size(), 1);
        f0 = fall_q[0];
        g = 0;
        while (cyc < f0 + 4 * DIV + 200 && g < FRAME) begin
            @(negedge clk);
            g++;
        end
        rst_n     = 1'b0;
        mon_abort = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", tx_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready_rise", tx_ready, 1);
        exp_q.delete();
        mon_abort = 1'b0;
        base = frames_done;
        push_byte(8'h81, acc);
        wait_frames(base + 1);
        wait_idle();

        // Simultaneous push and pop at the end of a stop bit
        fall_q.delete();
        base = frames_done;
        push_byte(8'hC3, k);
        push_byte(8'h5A, acc);
        g = 0;
        while (cyc < k + FRAME && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
        push_byte(8'h7E, acc);
        check("simul_push_edge", acc, k + 1 + FRAME);
        n = 0;
        d = 8'hE0;
        g = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (tx_ready && g < 20) begin
            exp_q.push_back(d);
            n++;
            d++;
            @(negedge clk);
            tx_data = d;
            g++;
        end
        tx_valid = 1'b0;
        check("simul_occupancy", n, 3);
        wait_frames(base + 3);
        check("simul_gap_1", fall_q[1] - fall_q[0], FRAME);
        check("simul_gap_2", fall_q[2] - fall_q[1], FRAME);
        rst_n     = 1'b0;
        mon_abort = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        mon_abort = 1'b0;
        check("flush_busy", busy, 0);

        g = 0;
        while (!small_done && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("small_test_done", small_done, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
